// File: rtl/lpr_pkg.sv
// Shared definitions for the image frame server: image geometry defaults,
// pixel/address widths, the control state encoding and an index-width helper.
package lpr_pkg;

  localparam int IMG_W_DEF = 256;
  localparam int IMG_H_DEF = 256;
  localparam int PIX_W     = 8;
  localparam int ADDR_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    START = 2'd2,
    BUSY  = 2'd3
  } state_e;

  // Bits needed to index a memory of 'depth' entries (at least 1).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/frame_ram.sv
// Single-frame pixel store: one write port, one registered read port.
// Reads of addresses beyond the frame return zero; a read of the address
// being written in the same cycle returns the previous contents.
module frame_ram
  import lpr_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF * IMG_H_DEF,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [PIX_W-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [PIX_W-1:0]  rd_data_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rd_data_q;

  // Pixel array write; the array sits in its own reset-free block.
  // NOTE: memories are never reset -- a reset would turn the array into
  // flops and cannot be mapped onto a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Registered read with out-of-range addresses forced to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (int'(rd_addr_i) < DEPTH) begin
      rd_data_q <= mem_q[rd_addr_i[IDX_W-1:0]];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/image_frame_server.sv
// Captures one camera frame into frame_ram, pulses start for the recognizer,
// waits for done, then counts the completed recognition and re-arms.
// Optional feature: define SOF_RESYNC_EN to require sof for frame start and
// to restart the frame at address 0 when sof appears mid-load.
module image_frame_server
  import lpr_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pix_in_data,
  input  logic              pix_in_sof,
  input  logic              pix_in_valid,
  output logic              pix_in_ready,
  input  logic [ADDR_W-1:0] image_pixel_addr,
  output logic [PIX_W-1:0]  image_pixel_val,
  output logic              start,
  input  logic              done,
  output logic [7:0]        frames_done
);

  localparam int                DEPTH = IMG_W * IMG_H;
  localparam int                IDX_W = idx_width(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [7:0]        frames_q, frames_d;
  logic              ready_q;
  logic              accept;
  logic              idle_take;   // accepted IDLE beat opens a frame
  logic              load_resync; // accepted LOAD beat restarts at address 0
  logic              wr_en;
  logic              wr_zero;
  logic [IDX_W-1:0]  wr_idx;

`ifdef SOF_RESYNC_EN
  assign idle_take   = pix_in_sof;
  assign load_resync = pix_in_sof;
`else
  logic unused_sof;
  assign unused_sof  = pix_in_sof;
  assign idle_take   = 1'b1;
  assign load_resync = 1'b0;
`endif

  assign accept = pix_in_valid & ready_q;

  // State, write counter, ready flag and completion counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      frames_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frames_q <= frames_d;
      ready_q  <= (state_d == IDLE) || (state_d == LOAD);
    end
  end

  // Next-state, counter and completion-count decode.
  // NOTE: combinational blocks assign a default to every output first so no
  // path leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    case (state_q)
      IDLE: begin
        if (accept && idle_take) begin
          cnt_d   = 16'd1;
          state_d = (DEPTH == 1) ? START : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (load_resync) begin
            cnt_d   = 16'd1;
            state_d = (DEPTH == 1) ? START : LOAD;
          end else if (cnt_q == LAST) begin
            state_d = START;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        if (done) begin
          state_d  = IDLE;
          frames_d = frames_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: start pulse and pixel write port control.
  always_comb begin
    start   = (state_q == START);
    wr_en   = 1'b0;
    wr_zero = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          wr_en   = idle_take;
          wr_zero = 1'b1;
        end
        LOAD: begin
          wr_en   = 1'b1;
          wr_zero = load_resync;
        end
        default: ;
      endcase
    end
  end

  assign wr_idx       = wr_zero ? '0 : cnt_q[IDX_W-1:0];
  assign pix_in_ready = ready_q;
  assign frames_done  = frames_q;

  frame_ram #(
    .DEPTH (DEPTH)
  ) u_frame_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i (pix_in_data),
    .rd_addr_i (image_pixel_addr),
    .rd_data_o (image_pixel_val)
  );

endmodule
